// File: rtl/bp_me_mem_link_bidir_credited.sv
// Bidirectional mem-link endpoint: serializes master commands and client responses into
// wormhole flits, deserializes inbound responses and commands, with credits and a return FIFO.
module bp_me_mem_link_bidir_credited #(
  parameter int msg_width_p           = 64,
  parameter int flit_width_p          = 32,
  parameter int cord_width_p          = 8,
  parameter int cid_width_p           = 2,
  parameter int len_width_p           = 4,
  parameter int num_outstanding_req_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic [cid_width_p-1:0]  my_cid_i,
  input  logic [cord_width_p-1:0] dst_cord_i,
  input  logic [cid_width_p-1:0]  dst_cid_i,
  input  logic [msg_width_p-1:0]  mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [msg_width_p-1:0]  mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i,
  output logic [msg_width_p-1:0]  mem_cmd_o,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0]  mem_resp_i,
  input  logic                    mem_resp_v_i,
  output logic                    mem_resp_ready_o,
  output logic [flit_width_p-1:0] cmd_flit_o,
  output logic                    cmd_v_o,
  input  logic                    cmd_ready_and_i,
  input  logic [flit_width_p-1:0] cmd_flit_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_and_o,
  output logic [flit_width_p-1:0] resp_flit_o,
  output logic                    resp_v_o,
  input  logic                    resp_ready_and_i,
  input  logic [flit_width_p-1:0] resp_flit_i,
  input  logic                    resp_v_i,
  output logic                    resp_ready_and_o
);

  localparam int hdr_w_lp   = 2*cord_width_p + 2*cid_width_p + len_width_p;
  localparam int pkt_w_lp   = hdr_w_lp + msg_width_p;
  localparam int nflit_lp   = (pkt_w_lp + flit_width_p - 1) / flit_width_p;
  localparam int buf_w_lp   = nflit_lp * flit_width_p;
  localparam int cnt_w_lp   = $clog2(nflit_lp + 1);
  localparam int cred_w_lp  = $clog2(num_outstanding_req_p + 1);
  localparam int ptr_w_lp   = (num_outstanding_req_p > 1) ? $clog2(num_outstanding_req_p) : 1;
  localparam int ret_w_lp   = cord_width_p + cid_width_p;
  localparam int src_lsb_lp = cord_width_p + cid_width_p + len_width_p;
  localparam logic [len_width_p-1:0] len_lp = len_width_p'(nflit_lp - 1);

  generate
    if (nflit_lp - 1 >= (1 << len_width_p)) begin : g_len_too_small
      $error("len_width_p too small for packet length");
    end
    if (num_outstanding_req_p < 1) begin : g_bad_outstanding
      $error("num_outstanding_req_p must be at least 1");
    end
  endgenerate

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} ser_state_e;

  function automatic logic [buf_w_lp-1:0] build_pkt(
    input logic [cord_width_p-1:0] dc,
    input logic [cid_width_p-1:0]  dcid,
    input logic [cord_width_p-1:0] sc,
    input logic [cid_width_p-1:0]  scid,
    input logic [msg_width_p-1:0]  msg
  );
    logic [buf_w_lp-1:0] p;
    p = '0;
    p[pkt_w_lp-1:0] = {msg, scid, sc, len_lp, dcid, dc};
    return p;
  endfunction

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(num_outstanding_req_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Channel 0 = master command out, channel 1 = client response out
  logic [1:0]              w_ser_start, w_ser_idle, w_ser_v, w_ser_ready;
  logic [buf_w_lp-1:0]     w_ser_pkt  [2];
  logic [flit_width_p-1:0] w_ser_flit [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ser
    ser_state_e                             r_state, w_state_next;
    logic [cnt_w_lp-1:0]                    r_cnt, w_cnt_next;
    logic [nflit_lp-1:0][flit_width_p-1:0]  r_pkt;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_ser_start[gi]) r_pkt <= w_ser_pkt[gi];
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        ST_IDLE: if (w_ser_start[gi]) begin
          w_state_next = ST_SEND;
          w_cnt_next   = '0;
        end
        ST_SEND: if (w_ser_ready[gi]) begin
          if (r_cnt == cnt_w_lp'(nflit_lp - 1)) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    assign w_ser_idle[gi] = (r_state == ST_IDLE) & ~reset_i;
    assign w_ser_v[gi]    = (r_state == ST_SEND) & ~reset_i;
    assign w_ser_flit[gi] = r_pkt[r_cnt];
  end

  // Channel 0 = inbound responses, channel 1 = inbound commands
  logic [1:0]              w_des_v, w_des_ready, w_des_full, w_des_clear;
  logic [flit_width_p-1:0] w_des_flit [2];
  logic [buf_w_lp-1:0]     w_des_pkt  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_des
    logic [cnt_w_lp-1:0]                    r_cnt;
    logic [nflit_lp-1:0][flit_width_p-1:0]  r_buf;

    assign w_des_full[gi]  = (r_cnt == cnt_w_lp'(nflit_lp));
    assign w_des_ready[gi] = ~w_des_full[gi] & ~reset_i;
    assign w_des_pkt[gi]   = r_buf;

    always_ff @(posedge clk_i) begin
      if (reset_i)                          r_cnt <= '0;
      else if (w_des_clear[gi])             r_cnt <= '0;
      else if (w_des_v[gi] & w_des_ready[gi]) r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (w_des_v[gi] & w_des_ready[gi]) r_buf[r_cnt] <= w_des_flit[gi];
    end
  end

  // Credits count master commands whose responses have not yet been consumed
  logic [cred_w_lp-1:0] r_credits;
  logic                 w_cmd_acc;

  assign w_cmd_acc = mem_cmd_v_i & mem_cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i)                                      r_credits <= '0;
    else if (w_cmd_acc && !mem_resp_yumi_i)           r_credits <= r_credits + 1'b1;
    else if (!w_cmd_acc && mem_resp_yumi_i && r_credits != '0) r_credits <= r_credits - 1'b1;
  end

  assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_yumi_i && !w_cmd_acc && (r_credits == '0)));

  // Return-address FIFO: remembers who sent each accepted client command
  logic [ret_w_lp-1:0]  r_fifo_mem [num_outstanding_req_p];
  logic [ptr_w_lp-1:0]  r_wr_ptr, r_rd_ptr;
  logic [cred_w_lp-1:0] r_fifo_cnt;
  logic                 w_fifo_full, w_fifo_empty, w_push, w_pop;
  logic [ret_w_lp-1:0]  w_push_data, w_fifo_head;

  assign w_fifo_full  = (r_fifo_cnt == cred_w_lp'(num_outstanding_req_p));
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_push       = mem_cmd_yumi_i & mem_cmd_v_o;
  assign w_pop        = mem_resp_v_i & mem_resp_ready_o;
  assign w_push_data  = {w_des_pkt[1][src_lsb_lp +: cord_width_p],
                         w_des_pkt[1][src_lsb_lp + cord_width_p +: cid_width_p]};
  assign w_fifo_head  = r_fifo_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_push_data;
  end

  assign w_ser_start[0] = w_cmd_acc;
  assign w_ser_start[1] = w_pop;
  assign w_ser_ready[0] = cmd_ready_and_i;
  assign w_ser_ready[1] = resp_ready_and_i;
  assign w_ser_pkt[0]   = build_pkt(dst_cord_i, dst_cid_i, my_cord_i, my_cid_i, mem_cmd_i);
  assign w_ser_pkt[1]   = build_pkt(w_fifo_head[ret_w_lp-1:cid_width_p], w_fifo_head[cid_width_p-1:0],
                                    my_cord_i, my_cid_i, mem_resp_i);

  assign w_des_v[0]     = resp_v_i;
  assign w_des_v[1]     = cmd_v_i;
  assign w_des_flit[0]  = resp_flit_i;
  assign w_des_flit[1]  = cmd_flit_i;
  assign w_des_clear[0] = mem_resp_yumi_i & mem_resp_v_o;
  assign w_des_clear[1] = w_push;

  assign mem_cmd_ready_o  = w_ser_idle[0] & (r_credits < cred_w_lp'(num_outstanding_req_p));
  assign cmd_flit_o       = w_ser_flit[0];
  assign cmd_v_o          = w_ser_v[0];
  assign mem_resp_ready_o = w_ser_idle[1] & ~w_fifo_empty;
  assign resp_flit_o      = w_ser_flit[1];
  assign resp_v_o         = w_ser_v[1];

  assign resp_ready_and_o = w_des_ready[0];
  assign mem_resp_v_o     = w_des_full[0] & ~reset_i;
  assign mem_resp_o       = w_des_pkt[0][hdr_w_lp +: msg_width_p];
  assign cmd_ready_and_o  = w_des_ready[1];
  assign mem_cmd_v_o      = w_des_full[1] & ~w_fifo_full & ~reset_i;
  assign mem_cmd_o        = w_des_pkt[1][hdr_w_lp +: msg_width_p];

  // Header and padding bits of received packets are only partly consumed
  logic w_unused;
  assign w_unused = ^{w_des_pkt[0], w_des_pkt[1]};

endmodule

// File: tb/tb_bp_me_mem_link_bidir_credited.sv
// Randomized self-checking bench for bp_me_mem_link_bidir_credited with a packet-level
// reference model (credit count, return-address queue, field-placed packet images).
module tb_bp_me_mem_link_bidir_credited;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  my_cord_i, dst_cord_i;
  logic [1:0]  my_cid_i, dst_cid_i;
  logic [63:0] mem_cmd_i, mem_resp_o, mem_cmd_o, mem_resp_i;
  logic        mem_cmd_v_i, mem_cmd_ready_o, mem_resp_v_o, mem_resp_yumi_i;
  logic        mem_cmd_v_o, mem_cmd_yumi_i, mem_resp_v_i, mem_resp_ready_o;
  logic [31:0] cmd_flit_o, cmd_flit_i, resp_flit_o, resp_flit_i;
  logic        cmd_v_o, cmd_ready_and_i, cmd_v_i, cmd_ready_and_o;
  logic        resp_v_o, resp_ready_and_i, resp_v_i, resp_ready_and_o;

  bp_me_mem_link_bidir_credited dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .my_cord_i(my_cord_i), .my_cid_i(my_cid_i), .dst_cord_i(dst_cord_i), .dst_cid_i(dst_cid_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .cmd_flit_o(cmd_flit_o), .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i),
    .cmd_flit_i(cmd_flit_i), .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o),
    .resp_flit_o(resp_flit_o), .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
    .resp_flit_i(resp_flit_i), .resp_v_i(resp_v_i), .resp_ready_and_o(resp_ready_and_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         exp_credits = 0;
  logic [9:0] ret_q[$];
  bit         cmd_pending = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Packet image: fields placed at their bit offsets, length N-1 = 2, zero pad to 96 bits
  function automatic logic [95:0] model_pkt(input logic [7:0] dc, input logic [1:0] dcid,
                                            input logic [7:0] sc, input logic [1:0] scid,
                                            input logic [63:0] msg);
    logic [95:0] p;
    p        = '0;
    p[7:0]   = dc;
    p[9:8]   = dcid;
    p[13:10] = 4'd2;
    p[21:14] = sc;
    p[23:22] = scid;
    p[87:24] = msg;
    return p;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    mem_cmd_v_i = 0; mem_resp_yumi_i = 0; mem_cmd_yumi_i = 0; mem_resp_v_i = 0;
    cmd_ready_and_i = 0; cmd_v_i = 0; resp_ready_and_i = 0; resp_v_i = 0;
    tick();
    tick();
    chk("rst_outputs", {mem_cmd_ready_o, mem_resp_v_o, mem_cmd_v_o, mem_resp_ready_o,
                        cmd_v_o, cmd_ready_and_o, resp_v_o, resp_ready_and_o}, 8'b0000_0000);
    reset_i = 1'b0;
    #1;
    chk("post_rst", {mem_cmd_ready_o, mem_resp_v_o, mem_cmd_v_o, mem_resp_ready_o,
                     cmd_v_o, cmd_ready_and_o, resp_v_o, resp_ready_and_o}, 8'b1000_0101);
    exp_credits = 0;
    cmd_pending = 0;
    ret_q.delete();
    $display("reset done");
  endtask

  task automatic master_send(input logic [63:0] msg, input logic [7:0] dc, input logic [1:0] dcid,
                             input logic [7:0] mc, input logic [1:0] mcid, input int stall_at,
                             input int stall_len, input bit with_yumi, output logic [95:0] got);
    logic [95:0] exp;
    int w;
    exp = model_pkt(dc, dcid, mc, mcid, msg);
    got = '0;
    dst_cord_i = dc; dst_cid_i = dcid; my_cord_i = mc; my_cid_i = mcid;
    mem_cmd_i = msg; mem_cmd_v_i = 1'b1;
    w = 0;
    while (!mem_cmd_ready_o && w < 20) begin tick(); w++; end
    chk("cmd_accept_ready", mem_cmd_ready_o, 1'b1);
    mem_resp_yumi_i = with_yumi;
    tick();
    mem_cmd_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    mem_cmd_i = rand64(); dst_cord_i = 8'($urandom); my_cord_i = 8'($urandom);
    dst_cid_i = 2'($urandom); my_cid_i = 2'($urandom);
    if (!with_yumi) exp_credits++;
    for (int k = 0; k < 3; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          cmd_ready_and_i = 1'b0;
          chk("cmd_v_stall", cmd_v_o, 1'b1);
          chk("cmd_flit_stall", cmd_flit_o, exp[k*32 +: 32]);
          tick();
        end
      end
      cmd_ready_and_i = 1'b1;
      chk("cmd_v", cmd_v_o, 1'b1);
      chk("cmd_flit", cmd_flit_o, exp[k*32 +: 32]);
      got[k*32 +: 32] = cmd_flit_o;
      tick();
    end
    cmd_ready_and_i = 1'b0;
    chk("cmd_v_done", cmd_v_o, 1'b0);
    chk("cmd_ready_after", mem_cmd_ready_o, exp_credits < 2);
    $display("master cmd msg=%h dst=%h/%0d credits=%0d", msg, dc, dcid, exp_credits);
  endtask

  task automatic resp_loopback(input logic [95:0] pkt, input logic [63:0] msg);
    int w;
    for (int k = 0; k < 3; k++) begin
      resp_flit_i = pkt[k*32 +: 32];
      resp_v_i = 1'b1;
      w = 0;
      while (!resp_ready_and_o && w < 20) begin tick(); w++; end
      chk("resp_in_ready", resp_ready_and_o, 1'b1);
      tick();
    end
    resp_v_i = 1'b0;
    resp_flit_i = $urandom;
    chk("mem_resp_v", mem_resp_v_o, 1'b1);
    chk("mem_resp_data", mem_resp_o, msg);
    chk("resp_in_full", resp_ready_and_o, 1'b0);
    $display("master resp msg=%h", mem_resp_o);
  endtask

  task automatic resp_yumi();
    mem_resp_yumi_i = 1'b1;
    tick();
    mem_resp_yumi_i = 1'b0;
    exp_credits--;
    chk("mem_resp_v_clr", mem_resp_v_o, 1'b0);
    chk("resp_in_ready_again", resp_ready_and_o, 1'b1);
    chk("cmd_ready_post_yumi", mem_cmd_ready_o, exp_credits < 2);
  endtask

  task automatic cmd_inject(input logic [95:0] pkt, input int nsend);
    int w;
    for (int k = 0; k < nsend; k++) begin
      cmd_flit_i = pkt[k*32 +: 32];
      cmd_v_i = 1'b1;
      w = 0;
      while (!cmd_ready_and_o && w < 20) begin tick(); w++; end
      chk("cmd_in_ready", cmd_ready_and_o, 1'b1);
      tick();
    end
    cmd_v_i = 1'b0;
    cmd_flit_i = $urandom;
    if (nsend == 3) begin
      cmd_pending = 1;
      chk("mem_cmd_v", mem_cmd_v_o, ret_q.size() < 2);
      chk("mem_cmd_data", mem_cmd_o, pkt[87:24]);
      chk("cmd_in_full", cmd_ready_and_o, 1'b0);
      $display("client cmd msg=%h src=%h/%0d", pkt[87:24], pkt[21:14], pkt[23:22]);
    end
  endtask

  task automatic client_yumi(input logic [7:0] sc, input logic [1:0] scid);
    mem_cmd_yumi_i = 1'b1;
    tick();
    mem_cmd_yumi_i = 1'b0;
    ret_q.push_back({sc, scid});
    cmd_pending = 0;
    chk("mem_cmd_v_clr", mem_cmd_v_o, 1'b0);
    chk("cmd_in_ready_again", cmd_ready_and_o, 1'b1);
  endtask

  task automatic client_respond(input logic [63:0] msg, input logic [7:0] mc, input logic [1:0] mcid);
    logic [95:0] exp;
    logic [9:0]  dst;
    bit          rdy;
    int          k, cyc;
    my_cord_i = mc; my_cid_i = mcid; mem_resp_i = msg; mem_resp_v_i = 1'b1;
    chk("client_resp_ready", mem_resp_ready_o, ret_q.size() > 0);
    tick();
    mem_resp_v_i = 1'b0;
    mem_resp_i = rand64(); my_cord_i = 8'($urandom); my_cid_i = 2'($urandom);
    dst = ret_q.pop_front();
    chk("cmd_v_after_pop", mem_cmd_v_o, cmd_pending);
    exp = model_pkt(dst[9:2], dst[1:0], mc, mcid, msg);
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 60) begin
      rdy = ($urandom_range(0, 3) != 0);
      resp_ready_and_i = rdy;
      chk("resp_v", resp_v_o, 1'b1);
      chk("resp_flit", resp_flit_o, exp[k*32 +: 32]);
      tick();
      if (rdy) k++;
      cyc++;
    end
    chk("resp_flit_count", k, 3);
    resp_ready_and_i = 1'b0;
    chk("resp_v_done", resp_v_o, 1'b0);
    $display("client resp msg=%h dst=%h/%0d", msg, dst[9:2], dst[1:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [95:0] got, g1, g2, g3, g4, pkt;
    logic [63:0] m, m1, m2, m3, m4;
    logic [7:0]  sc [2];
    logic [1:0]  scid [2];
    int          nc;

    my_cord_i = 0; my_cid_i = 0; dst_cord_i = 0; dst_cid_i = 0;
    mem_cmd_i = 0; mem_resp_i = 0; cmd_flit_i = 0; resp_flit_i = 0;
    do_reset();

    // Master round trip with fixed addresses
    master_send(64'hDEAD_BEEF_0123_4567, 8'h05, 2'd1, 8'h02, 2'd0, -1, 0, 0, got);
    chk("f0_dst_cord", got[7:0], 8'h05);
    chk("f0_dst_cid", got[9:8], 2'd1);
    chk("f0_len", got[13:10], 4'd2);
    chk("f0_src_cord", got[21:14], 8'h02);
    resp_loopback(got, 64'hDEAD_BEEF_0123_4567);
    resp_yumi();

    // Backpressure in the middle of flit 1
    m = rand64();
    master_send(m, 8'h11, 2'd2, 8'h22, 2'd3, 1, 5, 0, got);
    resp_loopback(got, m);
    resp_yumi();

    // Credit limit and simultaneous accept + yumi
    m1 = rand64(); m2 = rand64(); m3 = rand64(); m4 = rand64();
    master_send(m1, 8'h01, 2'd0, 8'h02, 2'd0, -1, 0, 0, g1);
    master_send(m2, 8'h03, 2'd1, 8'h02, 2'd0, -1, 0, 0, g2);
    resp_loopback(g1, m1);
    resp_yumi();
    resp_loopback(g2, m2);
    master_send(m3, 8'h04, 2'd2, 8'h02, 2'd0, -1, 0, 1, g3);
    master_send(m4, 8'h05, 2'd3, 8'h02, 2'd0, -1, 0, 0, g4);
    resp_loopback(g3, m3);
    resp_yumi();
    resp_loopback(g4, m4);
    resp_yumi();

    // Return routing and FIFO-full gating
    cmd_inject(model_pkt(8'h77, 2'd1, 8'h10, 2'd0, rand64()), 3);
    client_yumi(8'h10, 2'd0);
    cmd_inject(model_pkt(8'h77, 2'd1, 8'h20, 2'd3, rand64()), 3);
    client_yumi(8'h20, 2'd3);
    cmd_inject(model_pkt(8'h77, 2'd1, 8'h30, 2'd2, rand64()), 3);
    client_respond(rand64(), 8'h77, 2'd1);
    client_yumi(8'h30, 2'd2);
    client_respond(rand64(), 8'h77, 2'd1);
    client_respond(rand64(), 8'h77, 2'd1);

    // Reset in the middle of an inbound packet
    cmd_inject(model_pkt(8'h01, 2'd0, 8'h44, 2'd1, rand64()), 2);
    do_reset();
    pkt = model_pkt(8'h01, 2'd0, 8'h55, 2'd2, rand64());
    cmd_inject(pkt, 3);
    client_yumi(8'h55, 2'd2);
    client_respond(rand64(), 8'h09, 2'd3);

    // Randomized mix of master round trips and client bursts
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        m = rand64();
        master_send(m, 8'($urandom), 2'($urandom), 8'($urandom), 2'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, got);
        resp_loopback(got, m);
        resp_yumi();
      end else begin
        nc = int'($urandom_range(1, 2));
        for (int j = 0; j < nc; j++) begin
          sc[j] = 8'($urandom);
          scid[j] = 2'($urandom);
          cmd_inject(model_pkt(8'($urandom), 2'($urandom), sc[j], scid[j], rand64()), 3);
          client_yumi(sc[j], scid[j]);
        end
        for (int j = 0; j < nc; j++) client_respond(rand64(), 8'($urandom), 2'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_link_bidir_credited.md
# bp_me_mem_link_bidir_credited

Bidirectional mem-link endpoint. Serializes master-side memory commands into wormhole flits and deserializes the returning responses. Deserializes incoming commands for a local client and routes each client response back to the command's originator. Generalises the fixed master/client bidir link with:
- parametrised message and flit widths, and multi-flit packets;
- credit-limited outstanding master requests;
- a return-address FIFO, so a client can serve multiple requesters.

It sits between a CCE/IO mem port and the mem-NoC routers.

## Interface
Parameters:
- msg_width_p, 64, memory message width in bits (commands and responses).
- flit_width_p, 32, NoC flit width.
- cord_width_p, 8, router coordinate width.
- cid_width_p, 2, concentrator id width.
- len_width_p, 4, packet length field width.
- num_outstanding_req_p, 2, maximum un-answered master commands; also the return-FIFO depth. Must be ≥1.

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, synchronous active-high reset.
- my_cord_i / my_cid_i, in, cord_width_p / cid_width_p, own address.
- dst_cord_i / dst_cid_i, in, cord_width_p / cid_width_p, destination of master commands.
- Master command in: mem_cmd_i (in, msg_width_p), mem_cmd_v_i (in, 1), mem_cmd_ready_o (out, 1).
- Master response out: mem_resp_o (out, msg_width_p), mem_resp_v_o (out, 1), mem_resp_yumi_i (in, 1).
- Client command out: mem_cmd_o (out, msg_width_p), mem_cmd_v_o (out, 1), mem_cmd_yumi_i (in, 1).
- Client response in: mem_resp_i (in, msg_width_p), mem_resp_v_i (in, 1), mem_resp_ready_o (out, 1).
- Outbound command flits: cmd_flit_o (out, flit_width_p), cmd_v_o (out, 1), cmd_ready_and_i (in, 1).
- Inbound command flits: cmd_flit_i (in, flit_width_p), cmd_v_i (in, 1), cmd_ready_and_o (out, 1).
- Outbound response flits: resp_flit_o (out, flit_width_p), resp_v_o (out, 1), resp_ready_and_i (in, 1).
- Inbound response flits: resp_flit_i (in, flit_width_p), resp_v_i (in, 1), resp_ready_and_o (out, 1).

## Operation
- **Packet format (LSB first):** dst_cord, dst_cid, len, src_cord, src_cid, msg.
  - hdr_w = 2·cord_width_p + 2·cid_width_p + len_width_p.
  - pkt_w = hdr_w + msg_width_p.
  - N = ceil(pkt_w / flit_width_p).
  - len = N−1.
  - Flit k carries bits [k·flit_width_p +: flit_width_p]; the last flit is zero-padded.
  - N−1 < 2^len_width_p is required; violation is an elaboration error.
- **Master serializer (cmd_flit_o).**
  - States: IDLE, SEND.
  - mem_cmd_ready_o = IDLE && credits < num_outstanding_req_p.
  - Accept: latch the packet with dst = dst_cord_i/dst_cid_i and src = my_cord_i/my_cid_i, zero the flit counter, go to SEND.
  - In SEND, cmd_v_o=1. The counter advances on cmd_ready_and_i; after flit N−1 is taken, return to IDLE.
- **Credit counter** (width $clog2(num_outstanding_req_p+1)).
  - +1 on command accept, −1 on mem_resp_yumi_i; both in the same cycle leave it unchanged.
  - Decrement at 0 is an assertion error; the counter holds at 0.
- **Response deserializer (resp_flit_i → mem_resp_o).**
  - resp_ready_and_o=1 while fewer than N flits are held.
  - After the N-th flit: resp_ready_and_o=0 and mem_resp_v_o=1, with mem_resp_o = msg field, until mem_resp_yumi_i.
- **Client command deserializer (cmd_flit_i → mem_cmd_o).**
  - Same structure as the response deserializer.
  - mem_cmd_v_o = packet complete && return FIFO not full.
  - On mem_cmd_yumi_i: push {src_cord, src_cid} from the header, then clear the deserializer.
- **Client response serializer.**
  - mem_resp_ready_o = IDLE && FIFO not empty.
  - Accept: pop the FIFO head into dst, src = my_cord_i/my_cid_i, then send N flits on resp_flit_o exactly as the master serializer does.
  - Responses return in command order.
- **Return FIFO.**
  - Depth num_outstanding_req_p.
  - A push and pop in the same cycle is legal when neither full nor empty.
  - No push is possible while full, because mem_cmd_v_o is gated.
- **Configuration inputs** (my_*/dst_*) are sampled only at packet acceptance.

## Timing
- **Reset.** Every output valid/ready is 0 during reset. Afterwards: credits=0, FIFO empty, both serializers IDLE, both deserializers empty.
  - First cycle after reset: mem_cmd_ready_o=1, resp_ready_and_o=1, cmd_ready_and_o=1, mem_resp_ready_o=0.
- **Reset mid-packet** drops all partial flits and state; no output valid is asserted in the cycle after reset.
- **Serializer latency.** Accept at cycle t → flit 0 on cmd_v_o at t+1. With no backpressure, flit k appears at t+1+k. mem_cmd_ready_o is re-asserted at t+1+N if credits allow.
- **Deserializer latency.** N-th flit handshake at cycle t → mem_resp_v_o/mem_cmd_v_o=1 at t+1. Ready is re-asserted the cycle after yumi.
- All outputs are registered or decoded from registered state. No combinational path exists from any *_i handshake input to any *_o.
- **Flit handshake rule:** a flit transfers when v && ready_and. Output data is stable while v=1 and not ready_and.

## Test plan
Default parameters throughout: hdr_w=24, pkt_w=88, N=3, len=2.
- **Master round trip:** send mem_cmd_i=64'hDEAD_BEEF_0123_4567 with dst=(8'h05,2'd1), my=(8'h02,2'd0).
  - Expect 3 flits; flit0[7:0]=8'h05, flit0[9:8]=1, flit0[13:10]=2, flit0[21:14]=8'h02.
  - Loop the flits back on resp_flit_i and expect mem_resp_o to equal the sent word.
- **Credit limit:** issue 2 commands without responding → mem_cmd_ready_o=0. Yumi one response → ready=1 the next cycle. Simultaneous accept + yumi keeps the count at 1.
- **Backpressure:** hold cmd_ready_and_i=0 for 5 cycles in the middle of flit 1 → cmd_flit_o is stable, the flit is neither duplicated nor dropped, and the total is 3 flits.
- **Client return routing:** inbound commands come from src (8'h10,0) then (8'h20,3). Respond twice → response packet flit0 dst fields are 8'h10/0 then 8'h20/3, and src = my address.
- **FIFO full:** with depth 2 and no responses, a third complete inbound command holds mem_cmd_v_o=0 and cmd_ready_and_o=0. One response accept releases it the next cycle.
- **Reset mid-packet:** assert reset after 2 of 3 inbound flits, then send a fresh 3-flit packet → a single correct mem_cmd_o, with no ghost message.
